dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Posted-store FIFO between the MEM-stage store path and the data memory write port. Committed stores (word `sw`, byte `sb`) are accepted in one cycle and drained to the data memory one per cycle, in program order. This decouples the pipeline from data-memory write availability. Loads hitting the same memory word as a pending store raise a conflict flag so the hazard unit can stall until the store has drained.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  byte address of store
- st_data  in  32  store data; byte stores use [7:0]
- st_op  in  3  3'b000 word, 3'b001 byte; any other code is discarded
- st_pc  in  32  PC of the store, carried for the write trace
- ld_valid  in  1  a load is being looked up this cycle
- ld_addr  in  32  byte address of the load
- ld_conflict  out  1  load targets a word with a pending store
- dm_hold  in  1  data-memory write port unavailable this cycle
- dm_we  out  1  write enable to data memory
- dm_addr  out  32  head entry address
- dm_wd  out  32  head entry data
- dm_op  out  3  head entry op
- dm_pc  out  32  head entry PC
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Each entry holds addr, data, op and pc.
- st_ready = (count != DEPTH). It depends only on registered state and is not raised by a same-cycle drain.
- Push occurs when st_valid && st_ready && (st_op == 000 || st_op == 001). The entry is written at tail, and tail and count increment.
- If st_valid && st_ready and st_op is any other code, the store is consumed and dropped. Pointers and count are unchanged.
- Pop occurs when dm_we is high. The head entry is consumed at the clock edge, and head increments.
- dm_we = !empty && !dm_hold. dm_addr, dm_wd, dm_op and dm_pc combinationally reflect the head entry. They are 0 when empty.
- Simultaneous push and pop leaves count unchanged and moves both pointers.
- Word compare uses address bits [11:2] only, which matches the data memory index width.
- ld_conflict = ld_valid && (match on any occupied entry, OR match on the incoming store when it is pushed this cycle).
- The head entry being popped this cycle still counts as a conflict.
- Op codes 101 and other load codes on st_op are never enqueued.

## Timing
- Reset takes effect at the clock edge with reset high. head = tail = 0, count = 0, empty = 1, st_ready = 1, dm_we = 0, all dm_* outputs = 0, and ld_conflict = 0.
- Entry contents are don't-care after reset.
- Latency: a store pushed in cycle c is visible at dm_* in cycle c+1 if the buffer was empty. The data memory commits it at the end of cycle c+1 when dm_hold is low.
- No combinational path from st_* to dm_*; dm_* depend only on registered state.
- The combinational path from st_valid/st_op/st_addr/ld_addr to ld_conflict is permitted.
- Full: while count == DEPTH, st_ready = 0 even if a pop occurs in the same cycle. It returns to 1 the cycle after the pop.
- dm_hold held high: the head is held, no entries are lost, and the FIFO fills, then back-pressures.
- Reset mid-operation discards all pending stores, and dm_we drops the next cycle.

## Test plan
- Reset, then push sw addr 0x0000_0010 data 0xDEADBEEF pc 0x3000 in cycle 1 -> cycle 2: dm_we = 1, dm_addr = 0x10, dm_wd = 0xDEADBEEF, dm_op = 000; cycle 3: empty = 1.
- dm_hold = 1, push 5 stores (DEPTH = 4) -> st_ready = 0 after the 4th push and the 5th is not accepted. Release dm_hold -> stores drain in order on 4 consecutive cycles, and st_ready returns 1 one cycle after the first pop.
- Push st_op = 3'b101 to 0x20 -> count stays 0 and dm_we stays 0.
- Pending sb to 0x0000_0013 with dm_hold = 1; a load at 0x0000_0010 gives ld_conflict = 1 and a load at 0x0000_0014 gives 0. Release the hold -> ld_conflict = 0 the cycle after the pop.
- Same-cycle push sw 0x40 and load 0x40 on an empty buffer -> ld_conflict = 1 that cycle.
- Fill 2 entries with dm_hold = 1, assert reset for one cycle -> count = 0, dm_we = 0, st_ready = 1; no further DM writes occur.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Posted-store FIFO between the MEM-stage store path and the data-memory write port.
// Drains one committed sw/sb per cycle in program order; flags loads that hit a pending word.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_op,
    input  logic [31:0]                st_pc,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_conflict,
    input  logic                       dm_hold,
    output logic                       dm_we,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_wd,
    output logic [2:0]                 dm_op,
    output logic [31:0]                dm_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [2:0]    mem_op   [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          st_kind_ok;
    logic          push;
    logic          pop;
    logic          hit;
    logic [AW-1:0] idx;
    logic          unused_ld_bits;

    assign st_ready   = (count != FULL);
    assign empty      = (count == '0);
    assign st_kind_ok = (st_op == 3'b000) || (st_op == 3'b001);
    assign push       = st_valid && st_ready && st_kind_ok;
    assign dm_we      = !empty && !dm_hold;
    assign pop        = dm_we;

    assign dm_addr = empty ? '0 : mem_addr[head];
    assign dm_wd   = empty ? '0 : mem_data[head];
    assign dm_op   = empty ? '0 : mem_op[head];
    assign dm_pc   = empty ? '0 : mem_pc[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= st_addr;
            mem_data[tail] <= st_data;
            mem_op[tail]   <= st_op;
            mem_pc[tail]   <= st_pc;
        end
    end

    // Word match on [11:2]: occupied slots (head onward, count deep) plus the store entering now.
    always_comb begin
        hit = 1'b0;
        idx = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((i < 32'(count)) && (mem_addr[idx][11:2] == ld_addr[11:2]))
                hit = 1'b1;
        end
        if (push && (st_addr[11:2] == ld_addr[11:2]))
            hit = 1'b1;
        ld_conflict = ld_valid && hit;
    end

    assign unused_ld_bits = &{1'b0, ld_addr[31:12], ld_addr[1:0]};

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: per-cycle directed vectors plus a full-buffer drain sequence.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_op;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        dm_hold;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [2:0]  dm_op;
    logic [31:0] dm_pc;
    logic [2:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_op(st_op), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .dm_hold(dm_hold), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_op(dm_op), .dm_pc(dm_pc), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sv;
        logic [31:0] sa, sd;
        logic [2:0]  so;
        logic [31:0] sp;
        logic        lv;
        logic [31:0] la;
        logic        hold;
        logic        chk;
        logic        e_rdy, e_conf, e_we;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr, e_wd;
        logic [2:0]  e_op;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic sv, input logic [31:0] sa,
                                input logic [31:0] sd, input logic [2:0] so, input logic [31:0] sp,
                                input logic lv, input logic [31:0] la, input logic hold);
        vec_t v;
        v = '{default: '0};
        v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd; v.so = so; v.sp = sp;
        v.lv = lv; v.la = la; v.hold = hold;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic rdy, input logic conf, input logic we,
                                input logic [2:0] cnt, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] op, input logic [31:0] pc);
        vec_t v;
        v = vi;
        v.chk = 1'b1; v.e_rdy = rdy; v.e_conf = conf; v.e_we = we; v.e_cnt = cnt;
        v.e_addr = a; v.e_wd = d; v.e_op = op; v.e_pc = pc;
        return v;
    endfunction

    // Empty-buffer expectation: ready, no write, all dm_* zero.
    function automatic vec_t exz(input vec_t vi, input logic conf);
        return ex(vi, 1'b1, conf, 1'b0, 3'd0, 32'h0, 32'h0, 3'b000, 32'h0);
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; st_valid = v.sv; st_addr = v.sa; st_data = v.sd; st_op = v.so;
        st_pc = v.sp; ld_valid = v.lv; ld_addr = v.la; dm_hold = v.hold;
    endtask

    vec_t q[$];
    vec_t idle;
    logic [31:0] tr[$];
    logic [31:0] exp_tr[5];
    int accept_cyc;

    initial begin
        drive(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(exz(idle, 0));
        // single sw: visible next cycle, drained the cycle after
        q.push_back(exz(mk(0, 1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h3000, 0, 0, 0), 0));
        q.push_back(ex(idle, 1, 0, 1, 3'd1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h3000));
        q.push_back(exz(idle, 0));
        // fill under hold, 5th rejected, drain in order (pointers wrap here)
        q.push_back(exz(mk(0, 1, 32'h100, 32'h11, 3'b000, 32'h4000, 0, 0, 1), 0));
        q.push_back(ex(mk(0, 1, 32'h104, 32'h22, 3'b001, 32'h4004, 0, 0, 1), 1, 0, 0, 3'd1, 32'h100, 32'h11, 3'b000, 32'h4000));
        q.push_back(ex(mk(0, 1, 32'h108, 32'h33, 3'b000, 32'h4008, 0, 0, 1), 1, 0, 0, 3'd2, 32'h100, 32'h11, 3'b000, 32'h4000));
        q.push_back(ex(mk(0, 1, 32'h10C, 32'h44, 3'b000, 32'h400C, 0, 0, 1), 1, 0, 0, 3'd3, 32'h100, 32'h11, 3'b000, 32'h4000));
        q.push_back(ex(mk(0, 1, 32'h110, 32'h55, 3'b000, 32'h4010, 0, 0, 1), 0, 0, 0, 3'd4, 32'h100, 32'h11, 3'b000, 32'h4000));
        q.push_back(ex(idle, 0, 0, 1, 3'd4, 32'h100, 32'h11, 3'b000, 32'h4000));
        q.push_back(ex(idle, 1, 0, 1, 3'd3, 32'h104, 32'h22, 3'b001, 32'h4004));
        q.push_back(ex(idle, 1, 0, 1, 3'd2, 32'h108, 32'h33, 3'b000, 32'h4008));
        q.push_back(ex(idle, 1, 0, 1, 3'd1, 32'h10C, 32'h44, 3'b000, 32'h400C));
        q.push_back(exz(idle, 0));
        // unsupported op is consumed and dropped
        q.push_back(exz(mk(0, 1, 32'h20, 32'h99, 3'b101, 32'h4444, 0, 0, 0), 0));
        q.push_back(exz(idle, 0));
        // load conflict against a held sb
        q.push_back(exz(mk(0, 1, 32'h13, 32'hAB, 3'b001, 32'h5000, 0, 0, 1), 0));
        q.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 32'h10, 1), 1, 1, 0, 3'd1, 32'h13, 32'hAB, 3'b001, 32'h5000));
        q.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 32'h14, 1), 1, 0, 0, 3'd1, 32'h13, 32'hAB, 3'b001, 32'h5000));
        q.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 32'h1010, 1), 1, 1, 0, 3'd1, 32'h13, 32'hAB, 3'b001, 32'h5000));
        q.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 32'h10, 0), 1, 1, 1, 3'd1, 32'h13, 32'hAB, 3'b001, 32'h5000));
        q.push_back(exz(mk(0, 0, 0, 0, 0, 0, 1, 32'h10, 0), 0));
        // same-cycle push and load on empty buffer
        q.push_back(exz(mk(0, 1, 32'h40, 32'h77, 3'b000, 32'h6000, 1, 32'h40, 0), 1));
        q.push_back(ex(idle, 1, 0, 1, 3'd1, 32'h40, 32'h77, 3'b000, 32'h6000));
        q.push_back(exz(idle, 0));
        // reset flushes pending stores
        q.push_back(exz(mk(0, 1, 32'h80, 32'h1, 3'b000, 32'h7000, 0, 0, 1), 0));
        q.push_back(ex(mk(0, 1, 32'h84, 32'h2, 3'b000, 32'h7004, 0, 0, 1), 1, 0, 0, 3'd1, 32'h80, 32'h1, 3'b000, 32'h7000));
        q.push_back(ex(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 3'd2, 32'h80, 32'h1, 3'b000, 32'h7000));
        q.push_back(exz(idle, 0));
        q.push_back(exz(idle, 0));

        foreach (q[i]) begin
            @(negedge clk);
            drive(q[i]);
            #1;
            if (q[i].chk) begin
                total++;
                if ({st_ready, ld_conflict, dm_we, count, empty, dm_addr, dm_wd, dm_op, dm_pc} !==
                    {q[i].e_rdy, q[i].e_conf, q[i].e_we, q[i].e_cnt, (q[i].e_cnt == 3'd0),
                     q[i].e_addr, q[i].e_wd, q[i].e_op, q[i].e_pc}) begin
                    bad++;
                    $display("FAIL vec%0d: got rdy=%b conf=%b we=%b cnt=%0d emp=%b addr=%h wd=%h op=%b pc=%h; want rdy=%b conf=%b we=%b cnt=%0d addr=%h wd=%h op=%b pc=%h",
                             i, st_ready, ld_conflict, dm_we, count, empty, dm_addr, dm_wd, dm_op, dm_pc,
                             q[i].e_rdy, q[i].e_conf, q[i].e_we, q[i].e_cnt,
                             q[i].e_addr, q[i].e_wd, q[i].e_op, q[i].e_pc);
                end
            end
        end

        // Store offered while full and draining: accepted only once space exists, written exactly once.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(mk(0, 1, 32'h300 + 32'(4 * k), 32'(k), 3'b000, 32'h8000, 0, 0, 1));
        end
        @(negedge clk);
        drive(mk(0, 1, 32'h200, 32'hF0, 3'b000, 32'h8100, 0, 0, 0));
        accept_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (dm_we) tr.push_back(dm_addr);
            if (st_valid && st_ready && accept_cyc < 0) accept_cyc = c;
            @(negedge clk);
            if (accept_cyc >= 0) st_valid = 1'b0;
        end
        exp_tr = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h200};
        total++;
        if (accept_cyc != 1) begin
            bad++;
            $display("FAIL full_accept_cycle: got %0d want 1", accept_cyc);
        end
        total++;
        if (tr.size() != 5) begin
            bad++;
            $display("FAIL drain_count: got %0d want 5", tr.size());
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= tr.size() || tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL drain_order[%0d]: got %h want %h", k,
                         (k < tr.size()) ? tr[k] : 32'hXXXXXXXX, exp_tr[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
